// File: rtl/case_8_div_pkg.sv
// Shared definitions for the sequential signed divider.
// - state_e   : FSM encoding (IDLE, CALC, FIX, DONE)
// - cnt_width : iteration counter width for a given dividend width
// - CNT_WIDTH : counter width at the default 16-bit dividend
package case_8_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DIN0_WIDTH_DEF = 16;

    // Counter counts din0_WIDTH-1 down to 0.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIN0_WIDTH_DEF);

endpackage

// File: rtl/case_8_udiv_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Ports:
//   rem_i [W:0]  partial remainder before this step
//   dvs_i [W:0]  divisor magnitude
//   bit_i        next dividend bit (MSB first)
//   rem_o [W:0]  partial remainder after this step
//   q_o          quotient bit produced by this step
module case_8_udiv_step #(
    parameter int W = 8
) (
    input  logic [W:0] rem_i,
    input  logic [W:0] dvs_i,
    input  logic       bit_i,
    output logic [W:0] rem_o,
    output logic       q_o
);

    logic [W:0]   trial;
    logic [W+1:0] diff;

    always_comb begin
        trial = {rem_i[W-1:0], bit_i};
        diff  = {1'b0, trial} - {1'b0, dvs_i};
        // rem_i[W] is the bit shifted out of trial; if set, the true trial value
        // exceeds any divisor, so the subtraction must happen regardless of borrow.
        q_o   = rem_i[W] | ~diff[W+1];
        rem_o = q_o ? diff[W:0] : trial;
    end

endmodule

// File: rtl/case_8_sdiv_16s_8s_9_seq.sv
// Multi-cycle signed divider: din0 (signed) / din1 (signed) -> quot, rem,
// truncating toward zero; remainder carries the dividend's sign.
// Ports:
//   ap_clk, ap_rst_n  clock, asynchronous active-low reset
//   ce                clock enable; 0 freezes every register
//   ap_start          request, sampled only in IDLE
//   din0, din1        dividend / divisor, captured on accept
//   ap_ready          operands captured this cycle
//   ap_idle           FSM is in IDLE
//   ap_done           results valid (one effective cycle)
//   quot, rem         quotient (wrapped to dout_WIDTH) and remainder, held
//   dz, ovf           divide-by-zero and quotient-overflow flags, held
module case_8_sdiv_16s_8s_9_seq
    import case_8_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  dz,
    output logic                  ovf
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int WQ = dout_WIDTH;
    localparam int CW = cnt_width(W0);

    // ID is an instance tag only and drives no logic.
    if (ID < 0) begin : g_id_tag_only
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W0-1:0]   dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [W1:0]     prem_q, prem_d;   // partial remainder, one extra bit for |-2^(W1-1)|
    logic [W1:0]     dvs_q, dvs_d;
    logic            neg_dvd_q, neg_dvd_d;
    logic            neg_quo_q, neg_quo_d;
    logic            zero_q, zero_d;
    logic [W1-1:0]   din0_lo_q, din0_lo_d;
    logic [WQ-1:0]   quot_q, quot_d;
    logic [W1-1:0]   rem_q, rem_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic            accept;

    logic [W0-1:0]   abs0;
    logic [W1-1:0]   abs1;
    logic [W1:0]     step_rem;
    logic            step_q;
    logic [W0:0]     qf_mag, qf;
    logic [W1-1:0]   rem_mag, rem_fix;
    logic            ovf_fix;

    assign abs0 = din0[W0-1] ? (~din0 + W0'(1)) : din0;
    assign abs1 = din1[W1-1] ? (~din1 + W1'(1)) : din1;

    case_8_udiv_step #(.W(W1)) u_step (
        .rem_i (prem_q),
        .dvs_i (dvs_q),
        .bit_i (dvd_q[W0-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Sign fix-up: full-width quotient so that +2^(W0-1) is representable.
    always_comb begin
        qf_mag  = {1'b0, dvd_q};
        qf      = neg_quo_q ? (~qf_mag + (W0+1)'(1)) : qf_mag;
        rem_mag = prem_q[W1-1:0];
        rem_fix = neg_dvd_q ? (~rem_mag + W1'(1)) : rem_mag;
        // Fits in WQ signed bits iff all bits from WQ-1 upward are equal.
        ovf_fix = !((&qf[W0:WQ-1]) || !(|qf[W0:WQ-1]));
    end

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        prem_d    = prem_q;
        dvs_d     = dvs_q;
        neg_dvd_d = neg_dvd_q;
        neg_quo_d = neg_quo_q;
        zero_d    = zero_q;
        din0_lo_d = din0_lo_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    accept    = 1'b1;
                    state_d   = ST_CALC;
                    cnt_d     = CW'(W0 - 1);
                    dvd_d     = abs0;
                    prem_d    = '0;
                    dvs_d     = {1'b0, abs1};
                    neg_dvd_d = din0[W0-1];
                    neg_quo_d = din0[W0-1] ^ din1[W1-1];
                    zero_d    = (din1 == '0);
                    din0_lo_d = din0[W1-1:0];
                end
            end
            ST_CALC: begin
                prem_d = step_rem;
                dvd_d  = {dvd_q[W0-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (zero_q) begin
                    quot_d = '0;
                    rem_d  = din0_lo_q;
                    dz_d   = 1'b1;
                    ovf_d  = 1'b0;
                end else begin
                    quot_d = qf[WQ-1:0];
                    rem_d  = rem_fix;
                    dz_d   = 1'b0;
                    ovf_d  = ovf_fix;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            prem_q    <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_quo_q <= 1'b0;
            zero_q    <= 1'b0;
            din0_lo_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (ce) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            prem_q    <= prem_d;
            dvs_q     <= dvs_d;
            neg_dvd_q <= neg_dvd_d;
            neg_quo_q <= neg_quo_d;
            zero_q    <= zero_d;
            din0_lo_q <= din0_lo_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    // ap_ready marks the capture edge, so it is gated by ce and held low in reset.
    assign ap_ready = ap_rst_n & ce & accept;
    assign ap_idle  = (state_q == ST_IDLE);
    assign ap_done  = (state_q == ST_DONE);
    assign quot     = quot_q;
    assign rem      = rem_q;
    assign dz       = dz_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_case_8_sdiv_16s_8s_9_seq.sv
module tb_case_8_sdiv_16s_8s_9_seq;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ce;
    logic        ap_start;
    logic [15:0] din0;
    logic [7:0]  din1;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [8:0]  quot;
    logic [7:0]  rem;
    logic        dz;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    case_8_sdiv_16s_8s_9_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ce       (ce),
        .ap_start (ap_start),
        .din0     (din0),
        .din1     (din1),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .quot     (quot),
        .rem      (rem),
        .dz       (dz),
        .ovf      (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [8:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // C-semantics reference from plain integer arithmetic.
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [8:0] q, output logic [7:0] r,
                                    output logic z, output logic o);
        int sa, sb, qf, rf;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = '0; r = a[7:0]; z = 1'b1; o = 1'b0;
        end else begin
            qf = sa / sb;
            rf = sa % sb;
            q  = qf[8:0];
            r  = rf[7:0];
            z  = 1'b0;
            o  = (qf < -256) || (qf > 255);
        end
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of cycle 1.
    task automatic start_op(input logic [15:0] a, input logic [7:0] b, input string tag);
        din0 = a; din1 = b; ap_start = 1'b1;
        @(negedge ap_clk);
        check({tag, "_ready"}, ap_ready, 1);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
    endtask

    // Returns the cycle (accept = 0) of ap_done, or -1 on timeout; ends at posedge+1.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                lat = c;
                break;
            end
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic run_check(input logic [15:0] a, input logic [7:0] b,
                             input logic [8:0] eq, input logic [7:0] er,
                             input logic ez, input logic eo, input string tag);
        int lat;
        start_op(a, b, tag);
        wait_done(lat);
        check({tag, "_latency"}, lat, 18);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_dz"}, dz, ez);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        logic [8:0]  mq;
        logic [7:0]  mr;
        logic        mz, mo;
        logic [15:0] ra;
        logic [7:0]  rb;
        int          lat;
        bit          seen;

        vecs[0]  = '{16'd1000,  8'd7,   9'h08E, 8'h06, 1'b0, 1'b0};
        vecs[1]  = '{16'hFC18,  8'd7,   9'h172, 8'hFA, 1'b0, 1'b0};  // -1000/7
        vecs[2]  = '{16'd100,   8'hFD,  9'h1DF, 8'h01, 1'b0, 1'b0};  // 100/-3
        vecs[3]  = '{16'd1234,  8'd0,   9'h000, 8'hD2, 1'b1, 1'b0};
        vecs[4]  = '{16'h8000,  8'hFF,  9'h000, 8'h00, 1'b0, 1'b1};  // -32768/-1
        vecs[5]  = '{16'h7FFF,  8'd1,   9'h1FF, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{16'h8000,  8'h80,  9'h100, 8'h00, 1'b0, 1'b1};  // -32768/-128 = 256
        vecs[7]  = '{16'h7FFF,  8'h80,  9'h101, 8'h7F, 1'b0, 1'b0};  // 32767/-128 = -255 r 127
        vecs[8]  = '{16'd50,    8'd5,   9'h00A, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{16'hFFF9,  8'd2,   9'h1FD, 8'hFF, 1'b0, 1'b0};  // -7/2 = -3 r -1
        vecs[10] = '{16'hFFFB,  8'd0,   9'h000, 8'hFB, 1'b1, 1'b0};  // -5/0
        vecs[11] = '{16'd127,   8'h80,  9'h000, 8'h7F, 1'b0, 1'b0};  // 127/-128

        // Reset state, with ap_start high to confirm ap_ready stays low.
        ap_rst_n = 1'b0; ce = 1'b1; ap_start = 1'b1; din0 = 16'd1; din1 = 8'd1;
        #12;
        check("rst_idle", ap_idle, 1);
        check("rst_ready", ap_ready, 0);
        check("rst_done", ap_done, 0);
        check("rst_quot", quot, 0);
        check("rst_rem", rem, 0);
        check("rst_dz", dz, 0);
        check("rst_ovf", ovf, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1; ap_start = 1'b0;
        @(posedge ap_clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_check(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf,
                      $sformatf("vec%0d", i));
        end

        // Random operands against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 8'h00;
                1: rb = 8'h80;
                2: rb = 8'hFF;
                3: ra = 16'h8000;
                default: ;
            endcase
            ref_div(ra, rb, mq, mr, mz, mo);
            run_check(ra, rb, mq, mr, mz, mo, $sformatf("rnd%0d", i));
        end

        // ce toggling: ce=1 on even cycles only; ap_done spans cycles 35-36.
        din0 = 16'd1000; din1 = 8'd7; ap_start = 1'b1;
        @(negedge ap_clk);
        check("ce_ready", ap_ready, 1);
        for (int c = 1; c <= 37; c++) begin
            @(posedge ap_clk); #1;
            ap_start = 1'b0;
            ce = (c % 2 == 0);
            @(negedge ap_clk);
            if (c == 34) check("ce_done_c34", ap_done, 0);
            if (c == 36) begin
                check("ce_done_c36", ap_done, 1);
                check("ce_quot", quot, 9'h08E);
                check("ce_rem", rem, 8'h06);
            end
            if (c == 37) check("ce_done_c37", ap_done, 0);
        end
        @(posedge ap_clk); #1;
        ce = 1'b1;

        // ap_start held high: second accept on cycle 19, right after DONE.
        din0 = 16'd300; din1 = 8'd10; ap_start = 1'b1;
        @(negedge ap_clk);
        check("hold_ready0", ap_ready, 1);
        @(posedge ap_clk); #1;
        din0 = 16'hFF9C; din1 = 8'd7;  // -100 / 7
        lat = -1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge ap_clk);
            if (ap_done && lat < 0) begin
                lat = c;
                check("hold_quot0", quot, 9'd30);
                check("hold_rem0", rem, 8'd0);
            end
            if (c == 19) check("hold_ready19", ap_ready, 1);
            if (c < 19) begin
                @(posedge ap_clk); #1;
            end
        end
        check("hold_latency0", lat, 18);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        wait_done(lat);
        check("hold_latency1", lat, 18);
        check("hold_quot1", quot, 9'h1F2);  // -14
        check("hold_rem1", rem, 8'hFE);     // -2

        // Asynchronous reset in cycle 9 of a division.
        start_op(16'hFC18, 8'd7, "arst");
        repeat (8) @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b0;
        #1;
        check("arst_quot", quot, 0);
        check("arst_rem", rem, 0);
        check("arst_dz", dz, 0);
        check("arst_ovf", ovf, 0);
        check("arst_done", ap_done, 0);
        check("arst_ready", ap_ready, 0);
        check("arst_idle", ap_idle, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("arst_idle_after", ap_idle, 1);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge ap_clk);
            if (ap_done) seen = 1'b1;
        end
        check("arst_no_stale_done", seen, 0);
        @(posedge ap_clk); #1;
        run_check(16'd50, 8'd5, 9'd10, 8'd0, 1'b0, 1'b0, "arst_next");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
